opp_packet_rx: RTL and testbench
================================

// Module: opp_packet_rx
// PURPOSE
//  Upstream feeder of the game core: parses opponent-state packets arriving on the
//  byte-wide ethernet receive stream and drives r_opp_dir/r_opp_game/r_opp_rst plus
//  opponent position. Validated packets are double-buffered and committed only on a
//  video frame boundary, so game state never tears mid-frame. Also reports link health.
// PARAMETERS
//  HEADER          8'hA5  required value of packet byte 0
//  PKT_LEN         9      exact packet length in bytes (hdr + 7 payload + checksum)
//  TIMEOUT_FRAMES  60     frames without a commit before link_up drops
//  CNT_W           8      width of saturating error counter
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  axiiv        in   1      rx byte valid; high for the whole packet, low between packets
//  axiid        in   8      rx byte
//  new_frame    in   1      1-cycle pulse at start of vertical blank
//  r_opp_x      out  11     committed opponent x
//  r_opp_y      out  11     committed opponent y
//  r_opp_dir    out  9      committed opponent heading, 0..359 degrees
//  r_opp_game   out  3      committed opponent game status
//  r_opp_rst    out  1      committed opponent reset request
//  commit_pulse out  1      1-cycle pulse the cycle after outputs update
//  link_up      out  1      a commit occurred within the last TIMEOUT_FRAMES frames
//  err_count    out  CNT_W  rejected packets, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; shadow empty (pending=0); frame counter 0.
//  Packet (big-endian): b0=HEADER; x={b1[2:0],b2}; y={b3[2:0],b4}; dir={b5[0],b6};
//   b7: game=b7[2:0], rst=b7[4]; b8 = XOR of b0..b7. Unused bits ignored.
//  FSM (transitions evaluated each cycle on registered byte index idx and running xor):
//   IDLE: axiiv=1 -> RECV, capture b0 (idx=1).
//   RECV: axiiv=1 & idx<PKT_LEN -> capture, idx++; axiiv=1 & idx==PKT_LEN -> DROP.
//     axiiv=0 -> end of packet: accept iff idx==PKT_LEN, b0==HEADER, checksum ok,
//     dir<360; accept loads shadow, pending=1; else err_count++. Return to IDLE.
//   DROP (overlong): wait axiiv=0, then err_count++ once, -> IDLE.
//   Packet of length 1..PKT_LEN-1 is a short-packet error.
//  Accepted packet while pending=1 overwrites shadow (newest wins, no error).
//  Commit: new_frame=1 & pending=1 -> outputs <= shadow, pending=0 next cycle;
//   commit_pulse high the following cycle. Outputs hold between commits.
//  Same-cycle accept and new_frame: commit uses the shadow contents as registered
//   before that cycle (if pending); the newly accepted packet becomes pending for
//   the next frame. If pending was 0, nothing commits that frame.
//  r_opp_rst is a level from the committed packet, not a pulse.
//  Link: frame counter resets to 0 on commit, else increments on new_frame,
//   saturating at TIMEOUT_FRAMES; link_up=0 when counter==TIMEOUT_FRAMES, 1 after commit.
//  rst mid-packet: FSM to IDLE, partial packet dropped silently (no err increment);
//   remaining bytes of that packet (axiiv still high) are treated as a new packet.
//  Latency: last byte -> axiiv low -> shadow valid next cycle; visible on outputs
//   only after the next new_frame.
// TESTING
//  Good pkt A5,01,90,00,E0,01,0E,13,chk then new_frame -> x=400,y=224,dir=270,game=3,
//   rst=1, commit_pulse one cycle after commit, link_up=1, err_count=0.
//  Corrupted checksum, 8-byte short, 10-byte long, header 0x5A, dir=360 -> each
//   err_count +1, outputs unchanged after new_frame.
//  Two good pkts (x=10, x=20) before one new_frame -> x=20 committed; next new_frame
//   with no new pkt -> no commit_pulse.
//  Accept and new_frame in same cycle with prior pending x=5, new x=6 -> x=5 now,
//   x=6 after next new_frame.
//  Commit then 60 new_frame pulses, no pkts -> link_up falls on the 60th; good pkt +
//   new_frame -> link_up=1. 300 bad pkts with CNT_W=8 -> err_count holds 255.
//  rst asserted at byte 4 -> all outputs 0; following clean pkt parses correctly.

Source files
------------

// File: rtl/opp_packet_rx.sv
// Opponent-state packet receiver: parses byte-wide rx packets, double-buffers
// validated ones and commits them to the game core only on a video frame boundary.
module opp_packet_rx #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         PKT_LEN        = 9,
    parameter int         TIMEOUT_FRAMES = 60,
    parameter int         CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [7:0]       axiid,
    input  logic             new_frame,
    output logic [10:0]      r_opp_x,
    output logic [10:0]      r_opp_y,
    output logic [8:0]       r_opp_dir,
    output logic [2:0]       r_opp_game,
    output logic             r_opp_rst,
    output logic             commit_pulse,
    output logic             link_up,
    output logic [CNT_W-1:0] err_count
);

    localparam int IDX_W = $clog2(PKT_LEN + 1);
    localparam int FRM_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN);
    localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(TIMEOUT_FRAMES);
    localparam logic [FRM_W-1:0] FRM_PRE   = FRM_W'(TIMEOUT_FRAMES - 1);
    localparam logic [8:0]       DIR_LIMIT = 9'd360;
    localparam logic [CNT_W-1:0] ERR_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Running checksum: XOR of every byte including the checksum byte folds to zero.
    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       xor_r;
    logic             hdr_ok_r;
    logic [10:0]      cap_x_r;
    logic [10:0]      cap_y_r;
    logic [8:0]       cap_dir_r;
    logic [2:0]       cap_game_r;
    logic             cap_rst_r;

    logic [10:0]      sh_x_r;
    logic [10:0]      sh_y_r;
    logic [8:0]       sh_dir_r;
    logic [2:0]       sh_game_r;
    logic             sh_rst_r;
    logic             pending_r;

    logic [FRM_W-1:0] frame_cnt_r;
    logic             commit_d_r;

    logic             pkt_end_s;
    logic             accept_s;
    logic             reject_s;
    logic             commit_s;

    assign pkt_end_s = (state_r == S_RECV) && !axiiv;
    assign accept_s  = pkt_end_s && (idx_r == LAST_IDX) && hdr_ok_r &&
                       (xor_r == 8'h00) && (cap_dir_r < DIR_LIMIT);
    assign reject_s  = (pkt_end_s && !accept_s) || ((state_r == S_DROP) && !axiiv);
    assign commit_s  = new_frame && pending_r;

    // Receive FSM: byte capture, running checksum and overlong-packet drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            idx_r      <= '0;
            xor_r      <= 8'h00;
            hdr_ok_r   <= 1'b0;
            cap_x_r    <= 11'd0;
            cap_y_r    <= 11'd0;
            cap_dir_r  <= 9'd0;
            cap_game_r <= 3'd0;
            cap_rst_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (axiiv) begin
                        state_r  <= S_RECV;
                        idx_r    <= IDX_W'(1);
                        xor_r    <= axiid;
                        hdr_ok_r <= (axiid == HEADER);
                    end
                end
                S_RECV: begin
                    if (!axiiv) begin
                        state_r <= S_IDLE;
                    end else if (idx_r == LAST_IDX) begin
                        state_r <= S_DROP;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                        xor_r <= cksum_step(xor_r, axiid);
                        case (idx_r)
                            IDX_W'(1): cap_x_r[10:8]  <= axiid[2:0];
                            IDX_W'(2): cap_x_r[7:0]   <= axiid;
                            IDX_W'(3): cap_y_r[10:8]  <= axiid[2:0];
                            IDX_W'(4): cap_y_r[7:0]   <= axiid;
                            IDX_W'(5): cap_dir_r[8]   <= axiid[0];
                            IDX_W'(6): cap_dir_r[7:0] <= axiid;
                            IDX_W'(7): begin
                                cap_game_r <= axiid[2:0];
                                cap_rst_r  <= axiid[4];
                            end
                            default: ;
                        endcase
                    end
                end
                S_DROP: begin
                    if (!axiiv) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Shadow buffer: newest accepted packet wins; a commit in the same cycle takes the old copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_r    <= 11'd0;
            sh_y_r    <= 11'd0;
            sh_dir_r  <= 9'd0;
            sh_game_r <= 3'd0;
            sh_rst_r  <= 1'b0;
            pending_r <= 1'b0;
        end else if (accept_s) begin
            sh_x_r    <= cap_x_r;
            sh_y_r    <= cap_y_r;
            sh_dir_r  <= cap_dir_r;
            sh_game_r <= cap_game_r;
            sh_rst_r  <= cap_rst_r;
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end
    end

    // Committed outputs, delayed commit pulse and saturating reject counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opp_x      <= 11'd0;
            r_opp_y      <= 11'd0;
            r_opp_dir    <= 9'd0;
            r_opp_game   <= 3'd0;
            r_opp_rst    <= 1'b0;
            commit_d_r   <= 1'b0;
            commit_pulse <= 1'b0;
            err_count    <= '0;
        end else begin
            if (commit_s) begin
                r_opp_x    <= sh_x_r;
                r_opp_y    <= sh_y_r;
                r_opp_dir  <= sh_dir_r;
                r_opp_game <= sh_game_r;
                r_opp_rst  <= sh_rst_r;
            end
            commit_d_r   <= commit_s;
            commit_pulse <= commit_d_r;
            if (reject_s && (err_count != ERR_SAT)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    // Link health: frames since the last commit, saturating at the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= '0;
            link_up     <= 1'b0;
        end else if (commit_s) begin
            frame_cnt_r <= '0;
            link_up     <= 1'b1;
        end else if (new_frame && (frame_cnt_r != FRM_MAX)) begin
            frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            if (frame_cnt_r == FRM_PRE) begin
                link_up <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opp_packet_rx.sv
// Randomized self-checking bench for opp_packet_rx against a packet-level reference model.
module tb_opp_packet_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [7:0]  axiid;
    logic        new_frame;
    logic [10:0] r_opp_x;
    logic [10:0] r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        r_opp_rst;
    logic        commit_pulse;
    logic        link_up;
    logic [7:0]  err_count;

    opp_packet_rx dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .new_frame(new_frame),
        .r_opp_x(r_opp_x), .r_opp_y(r_opp_y), .r_opp_dir(r_opp_dir),
        .r_opp_game(r_opp_game), .r_opp_rst(r_opp_rst), .commit_pulse(commit_pulse),
        .link_up(link_up), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_sx, m_sy, m_sdir, m_sgame, m_srst;
    int m_x, m_y, m_dir, m_game, m_rst;
    int m_pend, m_err, m_cnt, m_link;

    logic [7:0] pkt [0:15];
    int         pkt_len;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function void model_reset();
        m_sx = 0; m_sy = 0; m_sdir = 0; m_sgame = 0; m_srst = 0;
        m_x = 0; m_y = 0; m_dir = 0; m_game = 0; m_rst = 0;
        m_pend = 0; m_err = 0; m_cnt = 0; m_link = 0;
    endfunction

    function bit model_frame();
        bit c;
        c = (m_pend != 0);
        if (c) begin
            m_x = m_sx; m_y = m_sy; m_dir = m_sdir; m_game = m_sgame; m_rst = m_srst;
            m_pend = 0;
            m_cnt = 0;
            m_link = 1;
        end else begin
            if (m_cnt < 60) m_cnt++;
            if (m_cnt == 60) m_link = 0;
        end
        return c;
    endfunction

    function void model_packet();
        logic [7:0] x;
        int         dir;
        bit         ok;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= pkt[i];
        dir = {pkt[5][0], pkt[6]};
        ok = (pkt_len == 9) && (pkt[0] == 8'hA5) && (x == pkt[8]) && (dir < 360);
        if (ok) begin
            m_sx = {pkt[1][2:0], pkt[2]};
            m_sy = {pkt[3][2:0], pkt[4]};
            m_sdir = dir;
            m_sgame = pkt[7][2:0];
            m_srst = pkt[7][4];
            m_pend = 1;
        end else if (m_err < 255) begin
            m_err++;
        end
    endfunction

    task automatic fix_cksum();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= pkt[i];
        pkt[8] = x;
    endtask

    // Well-formed packet with random junk in the ignored bit positions.
    task automatic build_good(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                              input logic [2:0] g, input logic r);
        logic [7:0] j;
        pkt_len = 9;
        pkt[0] = 8'hA5;
        j = 8'($urandom); pkt[1] = {j[7:3], x[10:8]};
        pkt[2] = x[7:0];
        j = 8'($urandom); pkt[3] = {j[7:3], y[10:8]};
        pkt[4] = y[7:0];
        j = 8'($urandom); pkt[5] = {j[7:1], d[8]};
        pkt[6] = d[7:0];
        j = 8'($urandom); pkt[7] = {j[7:5], r, j[3], g};
        fix_cksum();
    endtask

    task automatic check_outputs(input string tag);
        check_value({tag, ".x"}, 32'(r_opp_x), m_x);
        check_value({tag, ".y"}, 32'(r_opp_y), m_y);
        check_value({tag, ".dir"}, 32'(r_opp_dir), m_dir);
        check_value({tag, ".game"}, 32'(r_opp_game), m_game);
        check_value({tag, ".rst"}, 32'(r_opp_rst), m_rst);
        check_value({tag, ".link"}, 32'(link_up), m_link);
        check_value({tag, ".err"}, 32'(err_count), m_err);
    endtask

    // Called just after the edge that sampled new_frame.
    task automatic check_after_frame(input string tag, input bit c);
        check_outputs(tag);
        check_value({tag, ".pulse_early"}, 32'(commit_pulse), 0);
        step();
        check_value({tag, ".pulse"}, 32'(commit_pulse), 32'(c));
    endtask

    task automatic do_frame(input string tag);
        bit c;
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        c = model_frame();
        check_after_frame(tag, c);
    endtask

    task automatic send_pkt(input string tag, input bit nf_last);
        bit c;
        c = 1'b0;
        for (int i = 0; i < pkt_len; i++) begin
            axiiv = 1'b1;
            axiid = pkt[i];
            step();
        end
        axiiv = 1'b0;
        axiid = 8'h00;
        new_frame = nf_last;
        step();
        new_frame = 1'b0;
        if (nf_last) c = model_frame();
        model_packet();
        check_value({tag, ".err_after_pkt"}, 32'(err_count), m_err);
        if (nf_last) check_after_frame({tag, ".nf"}, c);
    endtask

    initial begin
        rst = 1'b1; axiiv = 1'b0; axiid = 8'h00; new_frame = 1'b0;
        model_reset();
        repeat (3) step();
        check_outputs("reset");
        check_value("reset.pulse", 32'(commit_pulse), 0);
        rst = 1'b0;
        step();

        // Reference good packet
        pkt_len = 9;
        pkt[0] = 8'hA5; pkt[1] = 8'h01; pkt[2] = 8'h90; pkt[3] = 8'h00;
        pkt[4] = 8'hE0; pkt[5] = 8'h01; pkt[6] = 8'h0E; pkt[7] = 8'h13;
        fix_cksum();
        send_pkt("good", 1'b0);
        do_frame("good_commit");
        check_value("good.x_abs", 32'(r_opp_x), 400);
        check_value("good.dir_abs", 32'(r_opp_dir), 270);

        // Each rejected kind, then a frame that must not commit
        build_good(11'd100, 11'd50, 9'd10, 3'd1, 1'b0); pkt[8] ^= 8'h01;
        send_pkt("bad_cksum", 1'b0);
        build_good(11'd101, 11'd51, 9'd11, 3'd2, 1'b0); pkt_len = 8;
        send_pkt("short8", 1'b0);
        build_good(11'd102, 11'd52, 9'd12, 3'd3, 1'b1); pkt_len = 10; pkt[9] = 8'h77;
        send_pkt("long10", 1'b0);
        build_good(11'd103, 11'd53, 9'd13, 3'd4, 1'b0); pkt[0] = 8'h5A; fix_cksum();
        send_pkt("hdr5a", 1'b0);
        build_good(11'd104, 11'd54, 9'd360, 3'd5, 1'b0);
        send_pkt("dir360", 1'b0);
        check_value("bad.err_abs", 32'(err_count), 5);
        do_frame("bad_nocommit");

        // Newest wins, then an empty frame
        build_good(11'd10, 11'd1, 9'd1, 3'd1, 1'b0); send_pkt("x10", 1'b0);
        build_good(11'd20, 11'd2, 9'd2, 3'd2, 1'b1); send_pkt("x20", 1'b0);
        do_frame("newest");
        check_value("newest.x_abs", 32'(r_opp_x), 20);
        do_frame("empty_frame");

        // Accept coinciding with new_frame
        build_good(11'd5, 11'd3, 9'd3, 3'd3, 1'b0); send_pkt("x5", 1'b0);
        build_good(11'd6, 11'd4, 9'd4, 3'd4, 1'b1); send_pkt("x6", 1'b1);
        check_value("same_cycle.x_abs", 32'(r_opp_x), 5);
        do_frame("after_same");
        check_value("after_same.x_abs", 32'(r_opp_x), 6);

        // Link timeout and recovery
        for (int i = 0; i < 60; i++) do_frame($sformatf("timeout%0d", i));
        check_value("timeout.link_abs", 32'(link_up), 0);
        build_good(11'd700, 11'd300, 9'd359, 3'd7, 1'b1); send_pkt("relink", 1'b0);
        do_frame("relink_commit");
        check_value("relink.link_abs", 32'(link_up), 1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            build_good(11'd0, 11'd0, 9'd0, 3'd0, 1'b0);
            pkt_len = 2;
            for (int k = 0; k < pkt_len; k++) begin
                axiiv = 1'b1; axiid = pkt[k]; step();
            end
            axiiv = 1'b0; step();
            model_packet();
        end
        check_value("sat.err_model", 32'(err_count), m_err);
        check_value("sat.err_abs", 32'(err_count), 255);

        // Reset in the middle of a packet
        build_good(11'd33, 11'd44, 9'd55, 3'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            axiiv = 1'b1; axiid = pkt[i]; step();
        end
        rst = 1'b1; axiiv = 1'b1; axiid = pkt[4]; step();
        rst = 1'b0; axiiv = 1'b0; axiid = 8'h00; step();
        model_reset();
        check_outputs("midrst");
        build_good(11'd1234 % 2048, 11'd77, 9'd180, 3'd2, 1'b1); send_pkt("post_rst", 1'b0);
        do_frame("post_rst_commit");

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            int kind;
            kind = $urandom_range(0, 8);
            build_good(11'($urandom), 11'($urandom), 9'($urandom_range(0, 359)),
                       3'($urandom), 1'($urandom));
            case (kind)
                3: pkt[8] ^= 8'(1 << $urandom_range(0, 7));
                4: pkt_len = $urandom_range(1, 8);
                5: begin
                    pkt_len = $urandom_range(10, 12);
                    for (int k = 9; k < pkt_len; k++) pkt[k] = 8'($urandom);
                end
                6: begin
                    pkt[0] = 8'hA5 ^ 8'($urandom_range(1, 255));
                    fix_cksum();
                end
                7: begin
                    pkt[5][0] = 1'b1;
                    pkt[6] = 8'($urandom_range(104, 255));
                    fix_cksum();
                end
                default: ;
            endcase
            send_pkt($sformatf("rnd%0d", it), ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 2) == 0) do_frame($sformatf("rnd_frame%0d", it));
        end
        do_frame("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
